// File: rtl/spi_reg_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_pkg
// Shared types and constants for the SPI register command sequencer.
//   state_e         : frame parser states (IDLE, CMD, WRITE, READ)
//   CMD_RW_BIT      : command bit selecting read (1) or write (0)
//   DEF_STATUS_BYTE : default byte shifted out while the command byte arrives
// No ports (package).
// -----------------------------------------------------------------------------
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_e;

    localparam int         CMD_RW_BIT      = 7;
    localparam logic [7:0] DEF_STATUS_BYTE = 8'hA5;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl_if
// Bundles the shifter-side byte handshake and the register bus of the SPI
// register command sequencer.
//   ss, rx_data, rx_valid          : from the SPI shifter (already synchronised)
//   tx_data                        : next byte to load into the shifter
//   reg_addr, reg_wdata            : register bus address / write data
//   reg_wr, reg_rd                 : one-cycle register strobes
//   reg_rdata                      : register read data (valid in reg_rd cycle)
//   busy                           : frame in progress
// Modports:
//   slave  : the sequencer itself (it is the SPI slave side)
//   master : the environment (shifter + register file)
// -----------------------------------------------------------------------------
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic              ss;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [7:0]        reg_rdata;
    logic              busy;

    modport slave (
        input  ss, rx_data, rx_valid, reg_rdata,
        output tx_data, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );

    modport master (
        output ss, rx_data, rx_valid, reg_rdata,
        input  tx_data, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );

endinterface

// File: rtl/spi_reg_addr_cnt.sv
// -----------------------------------------------------------------------------
// spi_reg_addr_cnt
// Loadable register-address counter, wrapping modulo 2^ADDR_W.
// Optional feature macro: SPI_REG_CTRL_AUTOINC_EN
//   defined     : i_inc advances the address by one (burst access)
//   not defined : i_inc is ignored, address holds the loaded value
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset (address -> 0)
//   i_load     : load i_load_val (has priority over i_inc)
//   i_load_val : address taken from the command byte
//   i_inc      : one access completed this cycle
//   o_addr     : current register address
// -----------------------------------------------------------------------------
module spi_reg_addr_cnt #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr
);

`ifdef SPI_REG_CTRL_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic [ADDR_W-1:0] r_addr;

    // Wrap from max to 0 falls out of the fixed-width add.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_val;
        end else if (AUTOINC && i_inc) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
// Command sequencer behind a byte-wide SPI slave shifter. Each frame is a
// command byte (bit 7: 1 = read, 0 = write; low ADDR_W bits: address) followed
// by data bytes. Writes strobe reg_wr one clock after each data byte; reads
// strobe reg_rd one clock after the command byte and after each dummy byte, and
// the read data is loaded into tx_data for the next byte slot.
// Optional feature macro: SPI_REG_CTRL_AUTOINC_EN (address auto-increment,
// implemented in spi_reg_addr_cnt).
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : spi_reg_ctrl_if.slave (shifter handshake + register bus)
// -----------------------------------------------------------------------------
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         ADDR_W      = 7,
    parameter logic [7:0] STATUS_BYTE = DEF_STATUS_BYTE
) (
    input  logic           clk,
    input  logic           rst,
    spi_reg_ctrl_if.slave  bus
);

    state_e            r_state;
    state_e            w_state_next;
    logic              r_reg_wr;
    logic              r_reg_rd;
    logic [7:0]        r_wdata;
    logic [7:0]        r_tx;
    logic              w_reg_wr_next;
    logic              w_reg_rd_next;
    logic              w_wdata_load;
    logic              w_status_load;
    logic              w_addr_load;
    logic [ADDR_W-1:0] w_addr;

    // ------------------------------------------------------------------
    // Next-state / strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        w_state_next  = r_state;
        w_reg_wr_next = 1'b0;
        w_reg_rd_next = 1'b0;
        w_wdata_load  = 1'b0;
        w_status_load = 1'b0;
        w_addr_load   = 1'b0;

        // Deselect wins over everything, including a byte arriving this cycle.
        if (bus.ss) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next  = CMD;
                    w_status_load = 1'b1;
                end
                CMD: begin
                    if (bus.rx_valid) begin
                        w_addr_load = 1'b1;
                        if (bus.rx_data[CMD_RW_BIT]) begin
                            w_state_next  = READ;
                            w_reg_rd_next = 1'b1;
                        end else begin
                            w_state_next  = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.rx_valid) begin
                        w_reg_wr_next = 1'b1;
                        w_wdata_load  = 1'b1;
                    end
                end
                READ: begin
                    // Received bytes are dummies; only their arrival matters.
                    if (bus.rx_valid) begin
                        w_reg_rd_next = 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_reg_wr <= 1'b0;
            r_reg_rd <= 1'b0;
            r_wdata  <= 8'h00;
            r_tx     <= 8'h00;
        end else begin
            r_state  <= w_state_next;
            r_reg_wr <= w_reg_wr_next;
            r_reg_rd <= w_reg_rd_next;
            if (w_wdata_load) begin
                r_wdata <= bus.rx_data;
            end
            // reg_rdata is only valid while reg_rd is high, so it is captured
            // on that edge; the status load only happens leaving IDLE, where
            // reg_rd can never be high.
            if (w_status_load) begin
                r_tx <= STATUS_BYTE;
            end else if (r_reg_rd) begin
                r_tx <= bus.reg_rdata;
            end
        end
    end

    // Address advances in the cycle after each completed access.
    spi_reg_addr_cnt #(
        .ADDR_W (ADDR_W)
    ) u_addr_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_addr_load),
        .i_load_val (bus.rx_data[ADDR_W-1:0]),
        .i_inc      (r_reg_wr | r_reg_rd),
        .o_addr     (w_addr)
    );

    assign bus.tx_data   = r_tx;
    assign bus.reg_addr  = w_addr;
    assign bus.reg_wdata = r_wdata;
    assign bus.reg_wr    = r_reg_wr;
    assign bus.reg_rd    = r_reg_rd;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command sequencer behind the byte-wide SPI slave shifter.
- Parses each SPI frame into a command byte followed by data bytes, and drives a simple register bus: address, write strobe and read strobe.
- Supplies the next transmit byte back to the shifter for read-back.
- Runs in the system clock domain; byte strobes arrive already synchronised.

Parameters:
- ADDR_W, 7: register address width; must be 1..7, taken from cmd[ADDR_W-1:0].
- STATUS_BYTE, 8'hA5: byte presented on tx_data while the command byte is shifting in.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- ss  input  1  slave select; 1 = frame inactive, 0 = frame active (level, synchronised)
- rx_data  input  8  byte received from shifter
- rx_valid  input  1  one-cycle pulse; rx_data valid this cycle
- tx_data  output  8  byte loaded into shifter for next byte slot
- reg_addr  output  ADDR_W  register address
- reg_wdata  output  8  write data
- reg_wr  output  1  one-cycle write strobe
- reg_rd  output  1  one-cycle read strobe
- reg_rdata  input  8  read data, combinationally valid in the reg_rd cycle
- busy  output  1  1 while a frame is active (state != IDLE)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; tx_data=8'h00; reg_addr=0; reg_wdata=0; reg_wr=0; reg_rd=0; busy=0.
- States:
  - IDLE: ss=0 moves to CMD next cycle and loads tx_data=STATUS_BYTE.
  - CMD: on rx_valid, capture cmd=rx_data and set reg_addr=cmd[ADDR_W-1:0]. If cmd[7]=0, go to WRITE. If cmd[7]=1, go to READ and issue reg_rd next cycle.
  - WRITE: each rx_valid gives reg_wdata=rx_data and reg_wr=1 for one cycle, 1 clk after rx_valid, at the current reg_addr. Address then advances (see Optional Feature) in the cycle after reg_wr.
  - READ: reg_rd pulses 1 clk after the command rx_valid, and 1 clk after each subsequent rx_valid. reg_rdata is captured into tx_data in the reg_rd cycle, so it is visible 2 clk after rx_valid. Address advances after each reg_rd. Received bytes in READ are dummies and ignored.
- Timing contract: tx_data is stable from 2 clk after rx_valid until the next rx_valid. The host must keep byte period >= 4 clk.
- ss=1 in any state returns to IDLE next cycle and clears reg_wr/reg_rd. No pending strobe is issued. tx_data and reg_addr hold their values.
- rx_valid and ss=1 in the same cycle: ss wins and the byte is dropped.
- rx_valid in IDLE is ignored.
- Address wraps modulo 2^ADDR_W (max to 0) with no flag.
- reg_wr and reg_rd are never asserted in the same cycle.
- A frame with only the command byte (read): exactly one reg_rd; no write.

Optional Feature:
- SPI_REG_CTRL_AUTOINC_EN defined: reg_addr increments by 1 after every reg_wr or reg_rd (burst access).
- Not defined: reg_addr holds the command address for the whole frame (FIFO-port access); all other timing is identical.

Decomposition:
- Package spi_reg_pkg holds:
  - state enum (IDLE, CMD, WRITE, READ)
  - CMD_RW_BIT = 7
  - default STATUS_BYTE
- Sub-module spi_reg_addr_cnt: loadable ADDR_W counter with load, inc and wrap. It is the natural carrier of the AUTOINC macro.

Test Plan:
- Write burst, AUTOINC on:
  - Stimulus: ss=0, bytes 8'h05, 8'h11, 8'h22, 8'h33, ss=1.
  - Required: reg_wr three times at addr 5,6,7 with wdata 11,22,33, each 1 clk after its rx_valid.
- Read burst:
  - Stimulus: regfile[0x10]=0x5A, [0x11]=0xC3; bytes 8'h90 then dummy 8'h00.
  - Required: tx_data=A5 during command; 0x5A 2 clk after first rx_valid; 0xC3 2 clk after second.
- Address wrap:
  - Stimulus: write cmd 8'h7F followed by 2 data bytes.
  - Required: writes to addr 0x7F then 0x00.
- Abort:
  - Stimulus: ss=1 in the same cycle as the second data rx_valid.
  - Required: no reg_wr for that byte; busy=0 next cycle; next frame starts cleanly in CMD.
- Reset mid-frame:
  - Stimulus: rst=0 during READ.
  - Required: all outputs 0 immediately (asynchronous); after release with ss=0, tx_data=A5.
- AUTOINC off:
  - Stimulus: write cmd 8'h20 followed by 3 data bytes.
  - Required: all three reg_wr at addr 0x20.
